// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer.
//   state_e              : sequencer FSM states (StTrap only with MISALIGN_TRAP_EN)
//   RESET_VECTOR_DEFAULT : default PC loaded on reset
//   PC_INC               : sequential PC increment in bytes
// Optional feature macro: MISALIGN_TRAP_EN
package pc_seq_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StReq,
    StWait,
    StExec
`ifdef MISALIGN_TRAP_EN
    , StTrap
`endif
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC               = 4;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer.
// Holds the PC, fetches each instruction over a valid/ready request and a response
// strobe, presents it to execute until exec_done_i, then redirects or advances by 4.
// Counts retired instructions.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   pc_src_i               : 1 = take branch_target_i on retire, 0 = PC+4
//   branch_target_i        : resolved branch/jump target
//   exec_done_i            : datapath finished current instruction
//   imem_req_valid_o/ready_i, imem_addr_o : fetch request channel
//   imem_rsp_valid_i, imem_rdata_i        : fetch response
//   instr_o, instr_valid_o, pc_out_o, pc_plus4_o : instruction to decode/execute
//   trap_o                 : misaligned-target trap (only with MISALIGN_TRAP_EN)
//   instret_o              : retired-instruction count
// Optional feature macro: MISALIGN_TRAP_EN
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VECTOR = SIZE'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_src_i,
  input  logic [SIZE-1:0] branch_target_i,
  input  logic            exec_done_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [SIZE-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [SIZE-1:0] imem_rdata_i,
  output logic [SIZE-1:0] instr_o,
  output logic            instr_valid_o,
  output logic [SIZE-1:0] pc_out_o,
  output logic [SIZE-1:0] pc_plus4_o,
  output logic            trap_o,
  output logic [31:0]     instret_o
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic [SIZE-1:0] pc_plus4;

  // Wraps modulo 2^SIZE by construction.
  assign pc_plus4 = pc_q + SIZE'(PC_INC);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (imem_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (imem_rsp_valid_i) begin
          instr_d = imem_rdata_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done_i) begin
          instret_d = instret_q + 32'd1;
          state_d   = StReq;
          if (pc_src_i) begin
`ifdef MISALIGN_TRAP_EN
            // Keep the faulting target visible on the PC while trapped.
            pc_d = branch_target_i;
            if (branch_target_i[1:0] != 2'b00) state_d = StTrap;
`else
            pc_d = branch_target_i & ~SIZE'(3);
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
`ifdef MISALIGN_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req_valid_o = (state_q == StReq);
  assign imem_addr_o      = pc_q;
  assign instr_o          = instr_q;
  assign instr_valid_o    = (state_q == StExec);
  assign pc_out_o         = pc_q;
  assign pc_plus4_o       = pc_plus4;
  assign instret_o        = instret_q;
`ifdef MISALIGN_TRAP_EN
  assign trap_o           = (state_q == StTrap);
`else
  assign trap_o           = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed fetch/retire sequences against a
// small memory model, plus a second instance exercising the PC wrap at the top of
// the address space.
module tb_pc_sequencer;

  localparam logic [31:0] Key = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        exec_done;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] instret;

  logic        b_rst;
  logic        b_req_valid;
  logic [31:0] b_addr;
  logic [31:0] b_instr;
  logic        b_instr_valid;
  logic [31:0] b_pc_out;
  logic [31:0] b_pc_plus4;
  logic        b_trap;
  logic [31:0] b_instret;

  pc_sequencer u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pc_src_i         (pc_src),
    .branch_target_i  (branch_target),
    .exec_done_i      (exec_done),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_addr_o      (addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rdata_i     (rdata),
    .instr_o          (instr),
    .instr_valid_o    (instr_valid),
    .pc_out_o         (pc_out),
    .pc_plus4_o       (pc_plus4),
    .trap_o           (trap),
    .instret_o        (instret)
  );

  // Always-ready memory answering every cycle, with done and pc_src fixed.
  pc_sequencer #(
    .SIZE         (32),
    .RESET_VECTOR (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk_i            (clk),
    .rst_i            (b_rst),
    .pc_src_i         (1'b0),
    .branch_target_i  (32'h0000_0000),
    .exec_done_i      (1'b1),
    .imem_req_valid_o (b_req_valid),
    .imem_req_ready_i (1'b1),
    .imem_addr_o      (b_addr),
    .imem_rsp_valid_i (1'b1),
    .imem_rdata_i     (32'h0000_0013),
    .instr_o          (b_instr),
    .instr_valid_o    (b_instr_valid),
    .pc_out_o         (b_pc_out),
    .pc_plus4_o       (b_pc_plus4),
    .trap_o           (b_trap),
    .instret_o        (b_instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus controls read by the negedge driver.
  logic        ready_en;
  int          rsp_delay;
  logic        auto_done;
  logic        redir_en;
  logic [31:0] redir_at;
  logic [31:0] redir_tgt;

  // Memory model state.
  logic        pending;
  int          cnt;
  logic [31:0] pend_addr;

  always @(negedge clk) begin
    rsp_valid = 1'b0;
    req_ready = ready_en;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (cnt == 0) begin
          rsp_valid = 1'b1;
          rdata     = pend_addr ^ Key;
          pending   = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (req_valid && ready_en) begin
        pending   = 1'b1;
        cnt       = rsp_delay;
        pend_addr = addr;
      end
    end
    exec_done     = auto_done && instr_valid;
    pc_src        = redir_en && (pc_out == redir_at);
    branch_target = redir_tgt;
  end

  logic [31:0] acc_q[$];
  logic [31:0] ret_pc[$];
  int          ret_cyc[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (req_valid && req_ready) acc_q.push_back(addr);
      if (instr_valid && exec_done) begin
        ret_pc.push_back(pc_out);
        ret_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ret(input int n, input int budget);
    int k = 0;
    while (ret_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (ret_pc.size() < n) check("timeout_retire", 32'd0, 32'd1);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc_q.size() < n) check("timeout_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_exec(input int budget);
    int k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    if (!instr_valid) check("timeout_exec", 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; b_rst = 1'b1;
    ready_en = 1'b1; rsp_delay = 0; auto_done = 1'b0;
    redir_en = 1'b0; redir_at = '0; redir_tgt = '0;
    pending = 1'b0; cnt = 0; pend_addr = '0;
    pc_src = 1'b0; branch_target = '0; exec_done = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rdata = '0;

    // Reset state.
    tick(); tick();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_instret", instret, 32'd0);
    check("rst_instr", instr, 32'd0);

    // Sequential fetches, then redirect to 0x100 when retiring PC 0x8.
    rst = 1'b0;
    auto_done = 1'b1;
    redir_en = 1'b1; redir_at = 32'h8; redir_tgt = 32'h100;
    wait_ret(3, 40);
    check("seq_acc0", acc_q[0], 32'h0);
    check("seq_acc1", acc_q[1], 32'h4);
    check("seq_acc2", acc_q[2], 32'h8);
    check("seq_ret0_pc", ret_pc[0], 32'h0);
    check("seq_instret3", instret, 32'd3);
    check("seq_period01", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
    check("seq_period12", 32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
    check("redir_addr", addr, 32'h100);
    check("redir_req_valid", 32'(req_valid), 32'd1);

    auto_done = 1'b0; redir_en = 1'b0;
    wait_exec(20);
    check("redir_pc_out", pc_out, 32'h100);
    check("redir_pc_plus4", pc_plus4, 32'h104);
    check("redir_instr", instr, 32'h100 ^ Key);

    // Request backpressure: ready held low while retiring 0x100.
    ready_en = 1'b0; auto_done = 1'b1;
    tick();
    auto_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_addr_stable", addr, 32'h104);
      check("bp_req_valid", 32'(req_valid), 32'd1);
      check("bp_instr_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    // Response delayed by three extra wait cycles.
    ready_en = 1'b1; rsp_delay = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rsp_wait_valid", 32'(instr_valid), 32'd0);
      check("rsp_wait_instr", instr, 32'h100 ^ Key);
    end
    tick();
    check("rsp_exec_valid", 32'(instr_valid), 32'd1);
    check("rsp_exec_instr", instr, 32'h104 ^ Key);
    check("rsp_exec_pc", pc_out, 32'h104);
    check("rsp_instret", instret, 32'd4);

    // Reset while waiting for a response.
    rsp_delay = 5; auto_done = 1'b1;
    n0 = acc_q.size();
    wait_acc(n0 + 1, 20);
    auto_done = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("wrst_req_valid", 32'(req_valid), 32'd0);
    check("wrst_addr", addr, 32'h0);
    check("wrst_instret", instret, 32'd0);
    check("wrst_instr_valid", 32'(instr_valid), 32'd0);
    check("wrst_instr", instr, 32'd0);

    // Misaligned branch target on the first instruction after reset.
    rst = 1'b0; rsp_delay = 0; auto_done = 1'b1;
    redir_en = 1'b1; redir_at = 32'h0; redir_tgt = 32'h102;
    n0 = ret_pc.size();
    wait_ret(n0 + 1, 20);
    check("mis_instret", instret, 32'd1);
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_req_valid", 32'(req_valid), 32'd0);
    check("mis_pc_held", pc_out, 32'h102);
    n0 = acc_q.size();
    repeat (5) tick();
    check("mis_no_fetch", 32'(acc_q.size()), 32'(n0));
    check("mis_trap_held", 32'(trap), 32'd1);
`else
    check("mis_trap", 32'(trap), 32'd0);
    check("mis_addr", addr, 32'h100);
    n0 = acc_q.size();
    wait_acc(n0 + 1, 10);
    check("mis_fetch", acc_q[n0], 32'h100);
`endif
    auto_done = 1'b0; redir_en = 1'b0;

    // Wrap instance: reset vector at the top of the address space.
    check("wrap_rst_addr", b_addr, 32'hFFFF_FFFC);
    check("wrap_rst_req", 32'(b_req_valid), 32'd0);
    b_rst = 1'b0;
    tick();
    check("wrap_req_valid", 32'(b_req_valid), 32'd1);
    check("wrap_req_addr", b_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_exec_valid", 32'(b_instr_valid), 32'd1);
    check("wrap_instr", b_instr, 32'h13);
    check("wrap_pc_plus4", b_pc_plus4, 32'h0);
    tick();
    check("wrap_next_addr", b_addr, 32'h0);
    check("wrap_instret", b_instret, 32'd1);
    check("wrap_trap", 32'(b_trap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and instruction-fetch sequencer for the RISC-V core: the consuming end of the branch-decision `pc_src` signal. It holds the PC and fetches each instruction over a valid/ready memory handshake. It presents the instruction to the datapath until execute signals completion, then redirects to the branch/jump target or advances by 4. It also counts retired instructions.

## Interface
- `SIZE`, 32, address/data width
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `pc_src` input 1: 1 = take `branch_target`, 0 = PC+4; sampled only on retire
- `branch_target` input SIZE: jump/branch target from ALU
- `exec_done` input 1: datapath finished current instruction
- `imem_req_valid` output 1: fetch request valid
- `imem_req_ready` input 1: memory accepts request
- `imem_addr` output SIZE: fetch address (= PC)
- `imem_rsp_valid` input 1: fetch data valid
- `imem_rdata` input SIZE: fetched instruction
- `instr` output SIZE: registered instruction to decoder
- `instr_valid` output 1: `instr`/`pc_out` valid for execute
- `pc_out` output SIZE: PC of `instr`
- `pc_plus4` output SIZE: `pc_out`+4, link value for JAL/JALR
- `trap` output 1: misaligned-target trap (see Configuration)
- `instret` output 32: retired-instruction count

## Operation
- FSM states: BOOT, REQ, WAIT, EXEC, TRAP.
- BOOT: entered on reset. No request is issued and `imem_rsp_valid` is ignored. Unconditionally → REQ next cycle.
- REQ: `imem_req_valid`=1 and `imem_addr`=PC. `imem_req_ready`=1 → WAIT. Otherwise hold, with address stable.
- WAIT: `imem_rsp_valid`=1 captures `imem_rdata` into `instr` → EXEC.
- EXEC: `instr_valid`=1. On `exec_done`=1:
  - PC ← `pc_src` ? `branch_target` : PC+4.
  - `instret` ← `instret`+1.
  - → REQ.
- `exec_done` outside EXEC and `imem_rsp_valid` outside WAIT are ignored.
- `jump_branch` encoding stays upstream; only the resolved `pc_src` arrives here.
- Arithmetic: PC+4 and `instret` wrap modulo 2^SIZE / 2^32 with no flag. PC 32'hFFFF_FFFC sequential → 32'h0000_0000.
- Memory shares `rst` and drops any outstanding response on reset, so a stale response never reaches WAIT.

## Timing
- Reset values:
  - state BOOT, PC=`RESET_VECTOR`, `instr`=0, `instret`=0.
  - `instr_valid`, `imem_req_valid`, `trap` all 0; `imem_addr`=`RESET_VECTOR`.
- Minimum instruction period is 3 cycles: REQ with ready, then WAIT with rsp, then EXEC with done. Each memory wait cycle adds one.
- All outputs are registered or derived from state/registers; there is no combinational path from inputs to outputs.
- New PC appears on `imem_addr` the cycle after retire.
- `rst` in any state: next cycle is BOOT with reset values, including mid-WAIT and TRAP.
- `exec_done` in the same cycle `instr_valid` first rises is legal and retires immediately.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A retire with `pc_src`=1 and `branch_target[1:0]`≠0 goes to TRAP instead of REQ.
  - That retire still increments `instret`.
  - In TRAP, `trap`=1, PC holds the faulting target, and no fetch is issued. Only `rst` exits.
- Not defined:
  - `branch_target[1:0]` is forced to 2'b00 on redirect.
  - `trap` is tied 0 and the TRAP state is absent.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum (BOOT, REQ, WAIT, EXEC, TRAP)
  - `RESET_VECTOR` default
  - `PC_INC` = 4
- Single module, no sub-module. The `instret` counter is inline; it is small enough not to justify a separate `instret_counter`.

## Test plan
- Reset release, memory always ready, rsp 1 cycle after request:
  - requests go to 0x0, 0x4, 0x8 with `pc_src`=0.
  - `instret` reads 3 after three retires.
  - instruction period is 3 cycles.
- Redirect: at `pc_out`=0x8, `pc_src`=1 with `branch_target`=0x100 → next `imem_addr`=0x100 and `pc_plus4` later equals 0x104.
- Backpressure:
  - `imem_req_ready` low 4 cycles → `imem_addr` stable, `instr_valid` stays 0.
  - rsp delayed 3 cycles → `instr` updates only on rsp.
- Reset asserted mid-WAIT → next cycle BOOT, `imem_addr`=`RESET_VECTOR`, `instret`=0, `instr_valid`=0.
- Misaligned target 0x102:
  - with `MISALIGN_TRAP_EN` → `trap`=1, no further requests, `instret` incremented.
  - without it → fetch from 0x100.
- Wrap: `RESET_VECTOR`=0xFFFF_FFFC, sequential retire → next fetch 0x0000_0000.
